fetch_decode: RTL and testbench

//  Front end that drives the Execute stage: fetches 32-bit instruction words from an external

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/instr_decoder.sv | 29 ++
 rtl/fetch_decode.sv | 134 +++++++++++++
 tb/tb_fetch_decode.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: micro-op codes, branch conditions, instruction field
// offsets, the fetch/decode FSM states and the Execute control bundle.
package cpu_pkg;

   localparam logic [4:0] UOP_NOP = 5'd0;
   localparam logic [4:0] UOP_ADD = 5'd1;
   localparam logic [4:0] UOP_AND = 5'd3;
   localparam logic [4:0] UOP_EOR = 5'd4;
   localparam logic [4:0] UOP_CMP = 5'd5;
   localparam logic [4:0] UOP_LSL = 5'd6;
   localparam logic [4:0] UOP_MOV = 5'd8;
   localparam logic [4:0] UOP_STR = 5'd9;
   localparam logic [4:0] UOP_LDR = 5'd10;
   localparam logic [4:0] UOP_HLT = 5'd31;

   localparam logic [3:0] COND_NONE = 4'b1111;
   localparam logic [3:0] COND_AL   = 4'b1110;

   localparam int UOP_LSB    = 27;
   localparam int COND_LSB   = 23;
   localparam int IMM_BIT    = 22;
   localparam int SEL_IN_LSB = 18;
   localparam int SEL_P0_LSB = 14;
   localparam int SEL_P1_LSB = 10;
   localparam int IMM_W      = 10;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_FLUSH,
      ST_HALT
   } fd_state_t;

   typedef struct packed {
      logic        num_to_rhs;
      logic [31:0] num;
      logic [3:0]  sel_p0;
      logic [3:0]  sel_p1;
      logic [3:0]  sel_in;
      logic [4:0]  uop;
      logic [3:0]  branch_cond;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      num_to_rhs:  1'b0,
      num:         32'd0,
      sel_p0:      4'd0,
      sel_p1:      4'd0,
      sel_in:      4'd0,
      uop:         UOP_NOP,
      branch_cond: COND_NONE
   };

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: one 32-bit instruction word in,
// Execute control bundle out.
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [31:0] word,
   output ctrl_t       ctrl
);

   logic [31:0] num_ext;

   assign num_ext[IMM_W-1:0] = word[IMM_W-1:0];

   for (genvar gi = IMM_W; gi < 32; gi++) begin : g_sext
      assign num_ext[gi] = word[IMM_W-1];
   end

   always_comb begin
      ctrl             = CTRL_NOP;
      ctrl.uop         = word[UOP_LSB +: 5];
      ctrl.branch_cond = word[COND_LSB +: 4];
      ctrl.num_to_rhs  = word[IMM_BIT];
      ctrl.sel_in      = word[SEL_IN_LSB +: 4];
      ctrl.sel_p0      = word[SEL_P0_LSB +: 4];
      ctrl.sel_p1      = word[SEL_P1_LSB +: 4];
      ctrl.num         = num_ext;
   end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: PC, branch redirect, stall capture and registered
// control bundle for Execute. Define FETCH_DECODE_HALT_EN to stop fetch on HLT.
module fetch_decode
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              stall,
   input  logic              global_disable,
   input  logic [31:0]       delta_instruction,
   output logic              num_to_rhs,
   output logic [31:0]       num,
   output logic [3:0]        sel_p0,
   output logic [3:0]        sel_p1,
   output logic [3:0]        sel_in,
   output logic [4:0]        uop,
   output logic [3:0]        branch_cond
`ifdef FETCH_DECODE_HALT_EN
   ,
   output logic              halted
`endif
);

   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] br_pc_reg, br_pc_next;
   fd_state_t         state_reg, state_next;
   ctrl_t             out_reg, out_next;
   logic [31:0]       held_word_reg, held_word_next;
   logic              held_valid_reg, held_valid_next;

   logic [31:0] cur_word;
   ctrl_t       dec_ctrl;

   if (ADDR_W < 32) begin : g_delta_hi
      logic unused_delta_hi;
      assign unused_delta_hi = ^delta_instruction[31:ADDR_W];
   end

   // A word latched during a stall takes precedence over the live imem output.
   assign cur_word = held_valid_reg ? held_word_reg : imem_data;

   instr_decoder u_decoder (
      .word (cur_word),
      .ctrl (dec_ctrl)
   );

   always_comb begin
      pc_next         = pc_reg;
      br_pc_next      = br_pc_reg;
      state_next      = state_reg;
      out_next        = out_reg;
      held_word_next  = held_word_reg;
      held_valid_next = held_valid_reg;

      if (global_disable && state_reg != ST_HALT) begin
         pc_next         = br_pc_reg + delta_instruction[ADDR_W-1:0];
         out_next        = CTRL_NOP;
         state_next      = ST_FLUSH;
         held_valid_next = 1'b0;
      end else if (stall) begin
         if (!held_valid_reg) begin
            held_word_next  = imem_data;
            held_valid_next = 1'b1;
         end
      end else begin
         held_valid_next = 1'b0;
         case (state_reg)
            ST_BOOT, ST_FLUSH: begin
               out_next   = CTRL_NOP;
               pc_next    = pc_reg + PC_ONE;
               state_next = ST_RUN;
            end
            ST_RUN: begin
`ifdef FETCH_DECODE_HALT_EN
               if (dec_ctrl.uop == UOP_HLT) begin
                  out_next   = CTRL_NOP;
                  state_next = ST_HALT;
               end else
`endif
               begin
                  out_next = dec_ctrl;
                  pc_next  = pc_reg + PC_ONE;
                  // The word being decoded was fetched from the address just before pc.
                  if (dec_ctrl.branch_cond != COND_NONE) begin
                     br_pc_next = pc_reg - PC_ONE;
                  end
               end
            end
            default: begin
               out_next = CTRL_NOP;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg         <= RESET_PC;
         br_pc_reg      <= RESET_PC;
         state_reg      <= ST_BOOT;
         out_reg        <= CTRL_NOP;
         held_word_reg  <= '0;
         held_valid_reg <= 1'b0;
      end else begin
         pc_reg         <= pc_next;
         br_pc_reg      <= br_pc_next;
         state_reg      <= state_next;
         out_reg        <= out_next;
         held_word_reg  <= held_word_next;
         held_valid_reg <= held_valid_next;
      end
   end

   assign imem_addr   = pc_reg;
   assign num_to_rhs  = out_reg.num_to_rhs;
   assign num         = out_reg.num;
   assign sel_p0      = out_reg.sel_p0;
   assign sel_p1      = out_reg.sel_p1;
   assign sel_in      = out_reg.sel_in;
   assign uop         = out_reg.uop;
   assign branch_cond = out_reg.branch_cond;

`ifdef FETCH_DECODE_HALT_EN
   assign halted = (state_reg == ST_HALT);
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios with literal
// expectations, then randomized stall/redirect/reset against a stream model.
module tb_fetch_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] imem_addr;
   logic [31:0] imem_data = 32'd0;
   logic        stall = 1'b0;
   logic        gd = 1'b0;
   logic [31:0] delta = 32'd0;
   logic        num_to_rhs;
   logic [31:0] num;
   logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
   logic [4:0]  uop;
`ifdef FETCH_DECODE_HALT_EN
   logic        halted;
`endif

   int tests = 0;
   int fails = 0;

   logic [31:0] mem [0:65535];

   fetch_decode dut (
      .clk               (clk),
      .rst               (rst),
      .imem_addr         (imem_addr),
      .imem_data         (imem_data),
      .stall             (stall),
      .global_disable    (gd),
      .delta_instruction (delta),
      .num_to_rhs        (num_to_rhs),
      .num               (num),
      .sel_p0            (sel_p0),
      .sel_p1            (sel_p1),
      .sel_in            (sel_in),
      .uop               (uop),
      .branch_cond       (branch_cond)
`ifdef FETCH_DECODE_HALT_EN
      ,
      .halted            (halted)
`endif
   );

   always #5 clk = ~clk;

   // synchronous instruction memory: data valid one cycle after the address
   always @(posedge clk) imem_data <= mem[imem_addr];

   // Stream model: next address to be issued plus a count of pending bubbles.
   logic        m_valid = 1'b0;
   logic        m_nop = 1'b1;
   logic        m_halted = 1'b0;
   logic [31:0] m_word = 32'd0;
   logic [15:0] m_next = 16'd0;
   logic [15:0] m_last_br = 16'd0;
   int          m_bubbles = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_valid   <= 1'b1;
         m_nop     <= 1'b1;
         m_next    <= 16'd0;
         m_last_br <= 16'd0;
         m_bubbles <= 1;
         m_halted  <= 1'b0;
      end else if (m_valid && !m_halted) begin
         if (gd) begin
            m_nop     <= 1'b1;
            m_next    <= m_last_br + delta[15:0];
            m_bubbles <= 1;
         end else if (!stall) begin
            if (m_bubbles > 0) begin
               m_nop     <= 1'b1;
               m_bubbles <= m_bubbles - 1;
            end
`ifdef FETCH_DECODE_HALT_EN
            else if (mem[m_next][31:27] == 5'd31) begin
               m_nop    <= 1'b1;
               m_halted <= 1'b1;
            end
`endif
            else begin
               m_nop  <= 1'b0;
               m_word <= mem[m_next];
               if (mem[m_next][26:23] != 4'hF) m_last_br <= m_next;
               m_next <= m_next + 16'd1;
            end
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   logic [53:0] exp_bundle, act_bundle;
   logic [15:0] exp_addr;
   always @(negedge clk) begin
      if (m_valid) begin
         if (m_nop)
            exp_bundle = {1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 5'd0, 4'hF};
         else
            exp_bundle = {m_word[22], {{22{m_word[9]}}, m_word[9:0]}, m_word[17:14],
                          m_word[13:10], m_word[21:18], m_word[31:27], m_word[26:23]};
         act_bundle = {num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond};
         exp_addr   = m_next + ((m_bubbles > 0) ? 16'd0 : 16'd1);
         tests++;
         if (act_bundle !== exp_bundle) begin
            fails++;
            $display("FAIL model_bundle t=%0t: got %h expected %h", $time, act_bundle, exp_bundle);
         end
         tests++;
         if (imem_addr !== exp_addr) begin
            fails++;
            $display("FAIL model_imem_addr t=%0t: got %h expected %h", $time, imem_addr, exp_addr);
         end
`ifdef FETCH_DECODE_HALT_EN
         tests++;
         if (halted !== m_halted) begin
            fails++;
            $display("FAIL model_halted t=%0t: got %0d expected %0d", $time, halted, m_halted);
         end
`endif
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i] = $urandom;
`ifdef FETCH_DECODE_HALT_EN
         if (i < 256 && mem[i][31:27] == 5'd31) mem[i][31:27] = 5'd1;
`endif
      end
      for (int i = 2; i <= 6; i++) mem[i][26:23] = 4'hF;
      for (int i = 15; i <= 30; i++) mem[i][26:23] = 4'hF;
      mem[0]      = 32'h47C4_0005;   // MOV r1,#5
      mem[1]      = 32'h0F90_4BFF;   // ADD r4=r1+r2, imm10=3FF
      mem[5]      = 32'h0F00_0000;   // ADD, cond AL (branch)
      mem[15]     = 32'h47C8_0007;   // MOV r2,#7
      mem[16]     = 32'h47CC_0009;   // MOV r3,#9
      mem[17]     = 32'h47D0_000B;   // MOV r4,#11
      mem[40]     = 32'hFF80_0000;   // uop 31
      mem[16'hFFFF] = 32'h0F00_0000; // branch at the top of the address space

      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;

      step(); chk("boot_nop", {27'd0, uop}, 32'd0);
      step();
      chk("mov_uop", {27'd0, uop}, 32'd8);
      chk("mov_sel_in", {28'd0, sel_in}, 32'd1);
      chk("mov_num", num, 32'd5);
      chk("mov_num_to_rhs", {31'd0, num_to_rhs}, 32'd1);
      step();
      chk("add_num", num, 32'hFFFF_FFFF);
      chk("add_uop", {27'd0, uop}, 32'd1);
      chk("add_sel_p0", {28'd0, sel_p0}, 32'd1);
      chk("add_sel_p1", {28'd0, sel_p1}, 32'd2);
      chk("add_sel_in", {28'd0, sel_in}, 32'd4);
      repeat (4) step();
      chk("branch_cond", {28'd0, branch_cond}, 32'hE);
      gd = 1'b1; delta = 32'd10;
      step(); gd = 1'b0; delta = 32'd0;
      chk("redir_addr", {16'd0, imem_addr}, 32'd15);
      chk("redir_nop", {27'd0, uop}, 32'd0);
      step();
      chk("flush_nop", {27'd0, uop}, 32'd0);
      chk("flush_addr", {16'd0, imem_addr}, 32'd16);
      step(); chk("target_num", num, 32'd7);

      stall = 1'b1;
      repeat (3) begin
         step();
         chk("stall_addr", {16'd0, imem_addr}, 32'd17);
         chk("stall_num", num, 32'd7);
      end
      stall = 1'b0;
      step(); chk("resume1_num", num, 32'd9);
      step(); chk("resume2_num", num, 32'd11);

      stall = 1'b1; gd = 1'b1; delta = 32'hFFFF_FFFA;
      step(); stall = 1'b0; gd = 1'b0; delta = 32'd0;
      chk("gd_stall_addr", {16'd0, imem_addr}, 32'h0000_FFFF);
      step();
      step();
      chk("top_branch_cond", {28'd0, branch_cond}, 32'hE);
      chk("seq_wrap_addr", {16'd0, imem_addr}, 32'd1);
      gd = 1'b1; delta = 32'd1;
      step(); gd = 1'b0; delta = 32'd0;
      chk("redir_wrap_addr", {16'd0, imem_addr}, 32'd0);
      step(); step();
      chk("wrap_target_num", num, 32'd5);

      gd = 1'b1; delta = 32'd41;
      step(); gd = 1'b0; delta = 32'd0;
      chk("hlt_redir_addr", {16'd0, imem_addr}, 32'd40);
      step(); step();
`ifdef FETCH_DECODE_HALT_EN
      chk("hlt_nop", {27'd0, uop}, 32'd0);
      chk("hlt_halted", {31'd0, halted}, 32'd1);
      repeat (3) step();
      chk("hlt_addr_stuck", {16'd0, imem_addr}, 32'd41);
      chk("hlt_still_nop", {27'd0, uop}, 32'd0);
`else
      chk("uop31_pass", {27'd0, uop}, 32'd31);
`endif

      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         rst   = ($urandom_range(0, 299) == 0);
         stall = ($urandom_range(0, 3) == 0);
         gd    = ($urandom_range(0, 19) == 0);
         delta = $urandom_range(0, 127) - 64;
         step();
      end
      rst = 1'b0; stall = 1'b0; gd = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
